serial_add_ctrl: RTL

Bit-serial adder controller. It adds two WIDTH-bit operands using one single-bit full-add step per cycle, built from two half-adder stages and a carry flop. A start/busy/done handshake sequences the operation. This is the low-area alternative to a parallel ripple adder, for blocks that can tolerate WIDTH+1 cycles of latency.

---
 rtl/serial_add_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-add step per cycle (two half-adder stages plus a carry flop),
// sequenced by a start/busy/done handshake. {cout,sum} = a+b after WIDTH+1 cycles.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic p_s, g1_s, s_s, g2_s;

  // State and datapath registers; reset aborts any operation in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rs_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rs_q    <= rs_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic and the single-bit full-add step built from two half adders.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rs_d    = rs_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    p_s  = ra_q[0] ^ rb_q[0];
    g1_s = ra_q[0] & rb_q[0];
    s_s  = p_s ^ carry_q;
    g2_s = p_s & carry_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          ra_d    = a;
          rb_d    = b;
          rs_d    = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        ra_d              = ra_q >> 1;
        rb_d              = rb_q >> 1;
        rs_d              = rs_q >> 1;
        rs_d[WIDTH-1]     = s_s;
        carry_d           = g1_s | g2_s;
        cnt_d             = cnt_q + CW'(1);
        // sum/cout only ever change on the edge that enters DONE.
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          sum_d   = rs_d;
          cout_d  = g1_s | g2_s;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
